// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-prediction types for the fetch BTB and the EX-side compare
package bp_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   // tag is kept at full pc[31:2] width so one struct serves every BTB depth
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      ctr_t        ctr;
   } btb_entry_t;

   function automatic ctr_t ctr_next(ctr_t c, logic taken);
      return taken ? ((c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1))
                   : ((c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1));
   endfunction

endpackage

// File: rtl/btb_2bit.sv
// btb_2bit: direct-mapped BTB with 2-bit saturating counters, lookup/update/allocate
module btb_2bit
   import bp_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [29:0] lk_word_i,
   output logic        hit_o,
   output logic [31:0] target_o,
   input  logic        upd_i,
   input  logic [29:0] upd_word_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i
);

   localparam int IDX_W = $clog2(DEPTH);

   btb_entry_t mem_q [DEPTH];

   logic [IDX_W-1:0] lk_idx, upd_idx;
   logic [29:0]      lk_tag, upd_tag;
   btb_entry_t       lk_e, upd_e;
   logic             upd_match;

   assign lk_idx    = lk_word_i[IDX_W-1:0];
   assign upd_idx   = upd_word_i[IDX_W-1:0];
   assign lk_tag    = lk_word_i >> IDX_W;
   assign upd_tag   = upd_word_i >> IDX_W;
   assign lk_e      = mem_q[lk_idx];
   assign upd_e     = mem_q[upd_idx];
   assign upd_match = upd_e.valid && (upd_e.tag == upd_tag);
   assign hit_o     = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
   assign target_o  = lk_e.target;

   // train matching entry, allocate on a taken miss; reset only drops valid bits
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
      end else if (upd_i) begin
         if (upd_match) mem_q[upd_idx].ctr <= ctr_next(upd_e.ctr, upd_taken_i);
         else if (upd_taken_i) mem_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target_i, ctr: CTR_WT};
      end
   end

endmodule

// File: rtl/if_stage_bp2.sv
// if_stage_bp2: fetch stage with PC, BTB-predicted next PC, mispredict redirect and IF/ID register
module if_stage_bp2
   import bp_pkg::*;
#(
   parameter int          BTB_DEPTH = 64,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        reset_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   input  logic        br_valid_ex_i,
   input  logic        jalr_ex_i,
   input  logic        br_taken_ex_i,
   input  logic [31:0] br_target_ex_i,
   input  logic [31:0] pc_ex_i,
   input  logic        hit_ex_i,
   output logic [31:0] inst_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc4_d_o,
   output logic        hit_d_o,
   output logic        mispredict_o
);

   logic [31:0] pc_q, pc_d, inst_q, inst_d, pcd_q, pcd_d, pc4_q, pc4_d;
   logic        hit_q, hit_d;
   logic        bp_hit;
   logic [31:0] bp_target, pc_plus4, pred_pc, correct_pc;

   btb_2bit #(.DEPTH(BTB_DEPTH)) u_btb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .lk_word_i   (pc_q[31:2]),
      .hit_o       (bp_hit),
      .target_o    (bp_target),
      .upd_i       (br_valid_ex_i),
      .upd_word_i  (pc_ex_i[31:2]),
      .upd_taken_i (br_taken_ex_i),
      .upd_target_i(br_target_ex_i)
   );

   assign pc_plus4     = pc_q + 32'd4;
   assign pred_pc      = bp_hit ? bp_target : pc_plus4;
   assign mispredict_o = jalr_ex_i | (br_valid_ex_i & (br_taken_ex_i != hit_ex_i));
   assign correct_pc   = br_taken_ex_i ? br_target_ex_i : pc_ex_i + 32'd4;
   assign imem_addr_o  = pc_q;
   assign inst_d_o     = inst_q;
   assign pc_d_o       = pcd_q;
   assign pc4_d_o      = pc4_q;
   assign hit_d_o      = hit_q;

   // redirect beats stall beats flush beats normal fetch
   always_comb begin
      pc_d   = pc_q;
      inst_d = inst_q;
      pcd_d  = pcd_q;
      pc4_d  = pc4_q;
      hit_d  = hit_q;
      if (mispredict_o) begin
         pc_d   = correct_pc;
         inst_d = '0;
         pcd_d  = '0;
         pc4_d  = '0;
         hit_d  = 1'b0;
      end else if (enable_i) begin
         pc_d   = pred_pc;
         inst_d = reset_i ? '0 : imem_data_i;
         pcd_d  = reset_i ? '0 : pc_q;
         pc4_d  = reset_i ? '0 : pc_plus4;
         hit_d  = reset_i ? 1'b0 : bp_hit;
      end
   end

   // PC and IF/ID registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q   <= RESET_PC;
         inst_q <= '0;
         pcd_q  <= '0;
         pc4_q  <= '0;
         hit_q  <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
         pcd_q  <= pcd_d;
         pc4_q  <= pc4_d;
         hit_q  <= hit_d;
      end
   end

endmodule

// File: tb/tb_if_stage_bp2.sv
// tb_if_stage_bp2: directed and randomized checks of if_stage_bp2 against a behavioural model
module tb_if_stage_bp2;

   logic        clk = 1'b0;
   logic        rst_n, en, flush, bv, jalr, taken, hitex;
   logic [31:0] tgt, pcex;
   logic [31:0] imem_addr, imem_data, inst_d, pc_d, pc4_d;
   logic        hit_d, mispredict;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_fn(logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16]};
   endfunction

   assign imem_data = imem_fn(imem_addr);

   if_stage_bp2 dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .reset_i(flush),
      .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .br_valid_ex_i(bv), .jalr_ex_i(jalr), .br_taken_ex_i(taken),
      .br_target_ex_i(tgt), .pc_ex_i(pcex), .hit_ex_i(hitex),
      .inst_d_o(inst_d), .pc_d_o(pc_d), .pc4_d_o(pc4_d), .hit_d_o(hit_d),
      .mispredict_o(mispredict)
   );

   // model: 64-entry table indexed by word address, tag = pc[31:8], counter as integer 0..3
   bit          m_valid [64];
   logic [23:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];
   logic [31:0] mpc, minst, mpcd, mpc4;
   logic        mhit;
   bit          mok = 0;

   function automatic bit m_lookup(logic [31:0] pc);
      int i = int'(pc[7:2]);
      return m_valid[i] && m_tag[i] == pc[31:8] && m_ctr[i] >= 2;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bv = 0; jalr = 0; taken = 0; hitex = 0; tgt = 0; pcex = 0; en = 1; flush = 0;
   endtask

   task automatic cycle();
      bit          mis, h;
      logic [31:0] cpc, nxt;
      int          i;
      #1;
      mis = jalr || (bv && (taken != hitex));
      if (mok) begin
         chk("imem_addr", imem_addr, mpc);
         chk("inst_d", inst_d, minst);
         chk("pc_d", pc_d, mpcd);
         chk("pc4_d", pc4_d, mpc4);
         chk("hit_d", {31'b0, hit_d}, {31'b0, mhit});
         chk("mispredict", {31'b0, mispredict}, {31'b0, mis});
      end
      h   = m_lookup(mpc);
      nxt = h ? m_tgt[mpc[7:2]] : mpc + 32'd4;
      cpc = taken ? tgt : pcex + 32'd4;
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < 64; k++) m_valid[k] = 0;
         mpc = 0; minst = 0; mpcd = 0; mpc4 = 0; mhit = 0; mok = 1;
      end else begin
         if (bv) begin
            i = int'(pcex[7:2]);
            if (m_valid[i] && m_tag[i] == pcex[31:8])
               m_ctr[i] = taken ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
            else if (taken) begin
               m_valid[i] = 1; m_tag[i] = pcex[31:8]; m_tgt[i] = tgt; m_ctr[i] = 2;
            end
         end
         if (mis) begin
            mpc = cpc; minst = 0; mpcd = 0; mpc4 = 0; mhit = 0;
         end else if (en) begin
            if (flush) begin
               minst = 0; mpcd = 0; mpc4 = 0; mhit = 0;
            end else begin
               minst = imem_fn(mpc); mpcd = mpc; mpc4 = mpc + 32'd4; mhit = h;
            end
            mpc = nxt;
         end
      end
      @(negedge clk);
   endtask

   task automatic branch(logic [31:0] pc, logic tk, logic [31:0] t, logic hx);
      idle(); bv = 1; pcex = pc; taken = tk; tgt = t; hitex = hx;
   endtask

   task automatic redirect(logic [31:0] a);
      idle(); jalr = 1; taken = 1; tgt = a; pcex = 32'h800;
      cycle();
      idle();
   endtask

   initial begin
      idle();
      rst_n = 0;
      @(negedge clk);
      cycle();
      cycle();
      rst_n = 1;
      chk("rst imem_addr", imem_addr, 32'h0);
      chk("rst inst_d", inst_d, 32'h0);
      chk("rst pc_d", pc_d, 32'h0);
      chk("rst pc4_d", pc4_d, 32'h0);
      chk("rst hit_d", {31'b0, hit_d}, 32'h0);
      cycle(); chk("seq pc_d 0", pc_d, 32'h0);
      cycle(); chk("seq pc_d 4", pc_d, 32'h4);
      cycle(); chk("seq pc_d 8", pc_d, 32'h8); chk("seq hit_d", {31'b0, hit_d}, 32'h0);

      branch(32'h40, 1, 32'h100, 0);
      #1 chk("alloc mispredict", {31'b0, mispredict}, 32'h1);
      cycle(); chk("alloc pc", imem_addr, 32'h100);
      redirect(32'h40);
      cycle(); chk("alloc hit_d", {31'b0, hit_d}, 32'h1); chk("alloc next pc", imem_addr, 32'h100);

      branch(32'h40, 0, 32'h100, 1);
      cycle(); chk("walk nt pc", imem_addr, 32'h44);
      redirect(32'h40);
      cycle(); chk("walk wnt hit_d", {31'b0, hit_d}, 32'h0); chk("walk wnt next", imem_addr, 32'h44);
      branch(32'h40, 1, 32'h100, 0); cycle();
      branch(32'h40, 1, 32'h100, 0); cycle();
      branch(32'h40, 0, 32'h100, 1); cycle();
      redirect(32'h40);
      cycle(); chk("walk wt hit_d", {31'b0, hit_d}, 32'h1); chk("walk wt next", imem_addr, 32'h100);

      en = 0; cycle(); cycle(); cycle();
      chk("stall pc", imem_addr, 32'h100);
      chk("stall pc_d", pc_d, 32'h40);
      jalr = 1; taken = 1; tgt = 32'h300; pcex = 32'h800;
      cycle(); chk("stall redirect pc", imem_addr, 32'h300); chk("stall redirect inst", inst_d, 32'h0);
      idle();

      idle(); jalr = 1; taken = 1; tgt = 32'h200; pcex = 32'h80;
      #1 chk("jalr mispredict", {31'b0, mispredict}, 32'h1);
      cycle(); chk("jalr pc", imem_addr, 32'h200);
      redirect(32'h80);
      cycle(); chk("jalr no alloc", {31'b0, hit_d}, 32'h0);

      branch(32'h140, 1, 32'h180, 0); cycle();
      redirect(32'h40);
      cycle(); chk("alias hit_d", {31'b0, hit_d}, 32'h0); chk("alias next", imem_addr, 32'h44);

      redirect(32'hFFFF_FFFC);
      cycle(); chk("wrap pc", imem_addr, 32'h0); chk("wrap pc4_d", pc4_d, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] picks [5];
         picks = '{32'h40, 32'h140, 32'h80, 32'h44, {22'b0, 8'($urandom_range(0, 255)), 2'b00}};
         idle();
         rst_n = ($urandom_range(0, 199) != 0);
         en    = ($urandom_range(0, 7) != 0);
         flush = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 9))
            0, 1, 2: bv = 1;
            3:       jalr = 1;
            default: ;
         endcase
         pcex  = picks[$urandom_range(0, 4)];
         tgt   = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
         taken = jalr ? 1'b1 : 1'($urandom_range(0, 1));
         hitex = 1'($urandom_range(0, 1));
         cycle();
      end
      rst_n = 1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
